dmi_req_sequencer: RTL and testbench
====================================

DMI_REQ_SEQUENCER -- requirements
Module: dmi_req_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of WAIT_RSP cycles before abort (used only with DMI_BUSY_TIMEOUT_EN).
REQ-002 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset. One clock; reset is synchronous and active-high.
REQ-003 SHALL have ports: update_i in 1, one-cycle Update-DR pulse; capture_i in 1, one-cycle Capture-DR pulse.
REQ-004 SHALL have ports: dmi_select_i in 1, DMI register selected; dr_addr_i in 7; dr_data_i in 32; dr_op_i in 2.
REQ-005 SHALL have ports: dmireset_i in 1, dtmcs.dmireset write pulse; hardreset_i in 1, dtmcs.dmihardreset write pulse.
REQ-006 SHALL have ports: req_valid_o out 1; req_ready_i in 1; req_addr_o out 7; req_data_o out 32; req_op_o out 2.
REQ-007 SHALL have ports: rsp_valid_i in 1; rsp_ready_o out 1; rsp_data_i in 32; rsp_err_i in 1.
REQ-008 SHALL have ports: capt_data_o out 32, last read data; error_o out 2, sticky DMI status (0 NoError, 2 OpFailed, 3 Busy).

Function
REQ-009 SHALL implement FSM IDLE, REQ, WAIT_RSP.
REQ-010 IDLE: update_i & dmi_select_i & error_o==0 & dr_op_i in {1 read, 2 write} SHALL register addr/data/op and go to REQ next cycle.
REQ-011 Update with op 0 (NOP) or 3 (reserved) SHALL issue no request and leave error_o unchanged.
REQ-012 REQ: req_valid_o=1, payload held stable until req_valid_o & req_ready_i; then go to WAIT_RSP.
REQ-013 WAIT_RSP: rsp_ready_o=1; on rsp_valid_i go to IDLE; if rsp_err_i, error_o<=2; otherwise, for reads, capt_data_o<=rsp_data_i.
REQ-014 rsp_ready_o SHALL be 1 in IDLE too; a response arriving in IDLE or REQ SHALL be discarded without state change.
REQ-015 Update_i or capture_i with dmi_select_i while state != IDLE SHALL set error_o<=3 if error_o==0; the update SHALL be dropped.
REQ-016 Update_i while error_o!=0 SHALL be ignored (sticky error).
REQ-017 dmireset_i SHALL clear error_o to 0 in every state, independent of all other inputs; FSM state and outstanding transaction are unaffected.
REQ-018 hardreset_i SHALL force IDLE, clear error_o, deassert req_valid_o next cycle; capt_data_o retained.
REQ-019 Priority when simultaneous: hardreset_i > dmireset_i > rsp/error update > update_i; update_i coincident with dmireset_i SHALL be ignored.
REQ-020 Minimum update-to-req_valid_o latency SHALL be 1 cycle; rsp_valid_i-to-IDLE latency 1 cycle.

Reset
REQ-021 rst_i SHALL set state IDLE, req_valid_o 0, req_addr_o/req_data_o/req_op_o 0, capt_data_o 0, error_o 0, timeout counter 0.
REQ-022 rst_i asserted mid-transaction SHALL abandon it; a later response SHALL be discarded per REQ-014.

Configuration
REQ-023 Macro DMI_BUSY_TIMEOUT_EN defined: counter increments each WAIT_RSP cycle; reaching TIMEOUT_CYCLES SHALL return to IDLE and set error_o<=2; counter clears on entering WAIT_RSP.
REQ-024 Macro undefined: no counter logic; WAIT_RSP exits only on rsp_valid_i, hardreset_i or rst_i.

Structure
REQ-025 Package dmi_seq_pkg SHALL hold dtm_op_e (NOP/READ/WRITE/RSVD), dmi_error_e (NoError=0, OpFailed=2, Busy=3), seq_state_e, DMI_ADDR_W=7.
REQ-026 Optional sub-module dmi_seq_timeout (counter + expiry flag) SHALL be instantiated only under DMI_BUSY_TIMEOUT_EN.

Verification
REQ-027 Read addr 0x11, req_ready_i=1, rsp after 3 cycles data 0xDEADBEEF -> one request, capt_data_o=0xDEADBEEF, error_o=0.
REQ-028 Update during WAIT_RSP -> error_o=3, no second request; later update ignored until dmireset_i; then write accepted.
REQ-029 rsp_err_i=1 on write -> error_o=2; dmireset_i concurrent with update -> error_o=0, no request issued.
REQ-030 hardreset_i in REQ with req_ready_i=0 -> req_valid_o=0 next cycle, state IDLE, late rsp_valid_i ignored.
REQ-031 With DMI_BUSY_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> IDLE and error_o=2 after 8 WAIT_RSP cycles.

Source files
------------

// File: rtl/dmi_seq_pkg.sv
// Shared types and constants for the DMI request sequencer.
//   dtm_op_e    : DTM operation field encoding (NOP/READ/WRITE/RSVD)
//   dmi_error_e : sticky DMI status values reported through dtmcs
//   seq_state_e : sequencer FSM states
package dmi_seq_pkg;

  localparam int unsigned DMI_ADDR_W = 7;
  localparam int unsigned DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    DTM_OP_NOP   = 2'd0,
    DTM_OP_READ  = 2'd1,
    DTM_OP_WRITE = 2'd2,
    DTM_OP_RSVD  = 2'd3
  } dtm_op_e;

  typedef enum logic [1:0] {
    DMI_NO_ERROR  = 2'd0,
    DMI_OP_FAILED = 2'd2,
    DMI_BUSY      = 2'd3
  } dmi_error_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP
  } seq_state_e;

  // Only reads and writes launch a bus transaction.
  function automatic logic is_bus_op(dtm_op_e op);
    return (op == DTM_OP_READ) || (op == DTM_OP_WRITE);
  endfunction

endpackage

// File: rtl/dmi_seq_timeout.sv
// Response timeout counter for the DMI request sequencer.
//   clk_i, rst_i : clock and synchronous active-high reset
//   en_i         : high for every cycle spent waiting for a response;
//                  low clears the counter, so each wait starts from zero
//   expired_o    : high during the TIMEOUT_CYCLES-th consecutive wait cycle
module dmi_seq_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmi_req_sequencer.sv
// DMI request sequencer: turns JTAG Update-DR of the DMI register into a
// single valid/ready bus request, waits for the response, keeps the last
// read data for the next Capture-DR and tracks the sticky DMI error status.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   update_i, capture_i     : one-cycle Update-DR / Capture-DR pulses
//   dmi_select_i            : DMI register is the selected DR
//   dr_addr_i/data_i/op_i   : shifted-in DMI fields
//   dmireset_i, hardreset_i : dtmcs reset pulses
//   req_*                   : request channel (valid/ready, payload held stable)
//   rsp_*                   : response channel (always ready)
//   capt_data_o             : data of the last successful read
//   error_o                 : sticky status (0 none, 2 op failed, 3 busy)
// Optional build macro: DMI_BUSY_TIMEOUT_EN aborts a wait after
// TIMEOUT_CYCLES cycles without a response.
module dmi_req_sequencer
  import dmi_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  update_i,
  input  logic                  capture_i,
  input  logic                  dmi_select_i,
  input  logic [DMI_ADDR_W-1:0] dr_addr_i,
  input  logic [31:0]           dr_data_i,
  input  logic [1:0]            dr_op_i,
  input  logic                  dmireset_i,
  input  logic                  hardreset_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [DMI_ADDR_W-1:0] req_addr_o,
  output logic [31:0]           req_data_o,
  output logic [1:0]            req_op_o,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [31:0]           rsp_data_i,
  input  logic                  rsp_err_i,
  output logic [31:0]           capt_data_o,
  output logic [1:0]            error_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  seq_state_e            state_q, state_d;
  logic                  req_valid_q, req_valid_d;
  logic [DMI_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  dtm_op_e               op_q, op_d;
  logic [31:0]           capt_q, capt_d;
  dmi_error_e            err_q, err_d;

  logic timeout_hit;
  logic busy_hit;
  logic op_failed;

`ifdef DMI_BUSY_TIMEOUT_EN
  dmi_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (state_q == ST_WAIT_RSP),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Any DMI access attempted while a transaction is outstanding.
  assign busy_hit = (update_i || capture_i) && dmi_select_i && (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    op_d      = op_q;
    capt_d    = capt_q;
    err_d     = err_q;
    op_failed = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (update_i && dmi_select_i && !dmireset_i && (err_q == DMI_NO_ERROR) &&
            is_bus_op(dtm_op_e'(dr_op_i))) begin
          addr_d  = dr_addr_i;
          data_d  = dr_data_i;
          op_d    = dtm_op_e'(dr_op_i);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_ready_i) begin
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid_i) begin
          state_d = ST_IDLE;
          if (rsp_err_i) begin
            err_d     = DMI_OP_FAILED;
            op_failed = 1'b1;
          end else if (op_q == DTM_OP_READ) begin
            capt_d = rsp_data_i;
          end
        end else if (timeout_hit) begin
          state_d   = ST_IDLE;
          err_d     = DMI_OP_FAILED;
          op_failed = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Error priority: hardreset > dmireset > response failure > busy.
    if (busy_hit && !op_failed && (err_q == DMI_NO_ERROR)) begin
      err_d = DMI_BUSY;
    end
    if (dmireset_i) begin
      err_d = DMI_NO_ERROR;
    end
    if (hardreset_i) begin
      state_d = ST_IDLE;
      err_d   = DMI_NO_ERROR;
      capt_d  = capt_q;
    end

    req_valid_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= DTM_OP_NOP;
      capt_q      <= '0;
      err_q       <= DMI_NO_ERROR;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
      capt_q      <= capt_d;
      err_q       <= err_d;
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_addr_o  = addr_q;
  assign req_data_o  = data_q;
  assign req_op_o    = op_q;
  assign rsp_ready_o = 1'b1;
  assign capt_data_o = capt_q;
  assign error_o     = err_q;

endmodule

// File: tb/tb_dmi_req_sequencer.sv
module tb_dmi_req_sequencer;

  localparam int TB_TIMEOUT = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        update_i, capture_i, dmi_select_i;
  logic [6:0]  dr_addr_i;
  logic [31:0] dr_data_i;
  logic [1:0]  dr_op_i;
  logic        dmireset_i, hardreset_i;
  logic        req_valid_o, req_ready_i;
  logic [6:0]  req_addr_o;
  logic [31:0] req_data_o;
  logic [1:0]  req_op_o;
  logic        rsp_valid_i, rsp_ready_o, rsp_err_i;
  logic [31:0] rsp_data_i;
  logic [31:0] capt_data_o;
  logic [1:0]  error_o;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  logic [31:0] exp_capt;

  // Reference model: transaction-level view of the sequencer.
  bit          m_busy, m_granted;
  logic [1:0]  m_err;
  logic [31:0] m_capt;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_op;
  int          m_wait;
  int          m_hs_exp;

  dmi_req_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .update_i(update_i), .capture_i(capture_i),
    .dmi_select_i(dmi_select_i), .dr_addr_i(dr_addr_i), .dr_data_i(dr_data_i),
    .dr_op_i(dr_op_i), .dmireset_i(dmireset_i), .hardreset_i(hardreset_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_data_o(req_data_o), .req_op_o(req_op_o), .rsp_valid_i(rsp_valid_i),
    .rsp_ready_o(rsp_ready_o), .rsp_data_i(rsp_data_i), .rsp_err_i(rsp_err_i),
    .capt_data_o(capt_data_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (req_valid_o && req_ready_i) hs_count <= hs_count + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    update_i = 0; capture_i = 0; dmi_select_i = 0; dr_addr_i = '0; dr_data_i = '0;
    dr_op_i = '0; dmireset_i = 0; hardreset_i = 0; req_ready_i = 0;
    rsp_valid_i = 0; rsp_data_i = '0; rsp_err_i = 0;
  endtask

  task automatic drive_update(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    update_i = 1; dmi_select_i = 1; dr_addr_i = a; dr_data_i = d; dr_op_i = op;
  endtask

  task automatic step_model();
    logic [1:0] new_err;
    bit failed;
    new_err = m_err;
    failed  = 0;
    if (m_busy && !m_granted && req_ready_i) m_hs_exp++;
    if (m_busy) begin
      if (!m_granted) begin
        if (req_ready_i) begin m_granted = 1; m_wait = 0; end
      end else if (rsp_valid_i) begin
        m_busy = 0;
        if (rsp_err_i) begin new_err = 2; failed = 1; end
        else if (m_op == 2'd1 && !hardreset_i) m_capt = rsp_data_i;
      end else begin
`ifdef DMI_BUSY_TIMEOUT_EN
        m_wait++;
        if (m_wait == TB_TIMEOUT) begin m_busy = 0; new_err = 2; failed = 1; end
`endif
      end
      if ((update_i || capture_i) && dmi_select_i && !failed && m_err == 2'd0) new_err = 3;
    end else if (update_i && dmi_select_i && !dmireset_i && m_err == 2'd0 &&
                 (dr_op_i == 2'd1 || dr_op_i == 2'd2)) begin
      m_busy = 1; m_granted = 0;
      m_addr = dr_addr_i; m_data = dr_data_i; m_op = dr_op_i;
    end
    if (dmireset_i) new_err = 0;
    m_err = new_err;
    if (hardreset_i) begin m_busy = 0; m_err = 0; end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", req_valid_o); end
    checks++; if ({req_addr_o, req_data_o, req_op_o} !== 41'd0) begin failures++; $display("FAIL reset_payload got=%h exp=0", {req_addr_o, req_data_o, req_op_o}); end
    checks++; if (capt_data_o !== 32'd0) begin failures++; $display("FAIL reset_capt got=%h exp=0", capt_data_o); end
    checks++; if (error_o !== 2'd0) begin failures++; $display("FAIL reset_error got=%0d exp=0", error_o); end
    checks++; if (rsp_ready_o !== 1'b1) begin failures++; $display("FAIL reset_rsp_ready got=%0b exp=1", rsp_ready_o); end
    rst_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_read();
    int hs0 = hs_count;
    req_ready_i = 1;
    drive_update(7'h11, 32'h0, 2'd1);
    @(negedge clk_i);
    update_i = 0;
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 7'h11 || req_op_o !== 2'd1) begin
      failures++; $display("FAIL read_req got v=%0b a=%h op=%0d exp v=1 a=11 op=1", req_valid_o, req_addr_o, req_op_o); end
    repeat (2) @(negedge clk_i);
    rsp_valid_i = 1; rsp_data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    rsp_valid_i = 0;
    exp_capt = 32'hDEADBEEF;
    checks++; if (capt_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL read_capt got=%h exp=deadbeef", capt_data_o); end
    checks++; if (error_o !== 2'd0) begin failures++; $display("FAIL read_error got=%0d exp=0", error_o); end
    checks++; if (hs_count - hs0 !== 1) begin failures++; $display("FAIL read_hs_count got=%0d exp=1", hs_count - hs0); end
    checks++; if (req_valid_o !== 1'b0) begin failures++; $display("FAIL read_valid_after got=%0b exp=0", req_valid_o); end
  endtask

  task automatic test_nop_reserved();
    logic [1:0] ops[3] = '{2'd0, 2'd3, 2'd1};
    for (int i = 0; i < 3; i++) begin
      drive_update(7'h2A, 32'h55, ops[i]);
      if (i == 2) dmi_select_i = 0;
      capture_i = (i == 1);
      dmi_select_i = (i != 2);
      @(negedge clk_i);
      clear_inputs();
      checks++; if (req_valid_o !== 1'b0 || error_o !== 2'd0) begin
        failures++; $display("FAIL nop_case%0d got v=%0b err=%0d exp v=0 err=0", i, req_valid_o, error_o); end
    end
  endtask

  task automatic test_busy();
    int hs0 = hs_count;
    req_ready_i = 1;
    drive_update(7'h22, 32'hA5A50001, 2'd2);
    @(negedge clk_i); update_i = 0;
    @(negedge clk_i);
    drive_update(7'h23, 32'h0, 2'd1);
    @(negedge clk_i); update_i = 0;
    checks++; if (error_o !== 2'd3) begin failures++; $display("FAIL busy_set got=%0d exp=3", error_o); end
    rsp_valid_i = 1; rsp_data_i = 32'h11112222;
    @(negedge clk_i); rsp_valid_i = 0;
    checks++; if (hs_count - hs0 !== 1 || error_o !== 2'd3) begin
      failures++; $display("FAIL busy_no_second_req got hs=%0d err=%0d exp hs=1 err=3", hs_count - hs0, error_o); end
    checks++; if (capt_data_o !== exp_capt) begin failures++; $display("FAIL busy_write_no_capt got=%h exp=%h", capt_data_o, exp_capt); end
    drive_update(7'h24, 32'h0, 2'd1);
    @(negedge clk_i); update_i = 0;
    checks++; if (req_valid_o !== 1'b0 || error_o !== 2'd3) begin
      failures++; $display("FAIL sticky_ignore got v=%0b err=%0d exp v=0 err=3", req_valid_o, error_o); end
    dmireset_i = 1;
    @(negedge clk_i); dmireset_i = 0;
    checks++; if (error_o !== 2'd0) begin failures++; $display("FAIL dmireset_clear got=%0d exp=0", error_o); end
    drive_update(7'h33, 32'hCAFE0002, 2'd2);
    @(negedge clk_i); update_i = 0;
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 7'h33 || req_data_o !== 32'hCAFE0002 || req_op_o !== 2'd2) begin
      failures++; $display("FAIL write_after_reset got v=%0b a=%h d=%h op=%0d exp v=1 a=33 d=cafe0002 op=2",
                           req_valid_o, req_addr_o, req_data_o, req_op_o); end
    @(negedge clk_i);
    rsp_valid_i = 1;
    @(negedge clk_i); rsp_valid_i = 0;
    checks++; if (hs_count - hs0 !== 2 || error_o !== 2'd0) begin
      failures++; $display("FAIL busy_final got hs=%0d err=%0d exp hs=2 err=0", hs_count - hs0, error_o); end
  endtask

  task automatic test_rsp_err();
    int hs0;
    req_ready_i = 1;
    drive_update(7'h40, 32'h0BADBAD0, 2'd2);
    @(negedge clk_i); update_i = 0;
    @(negedge clk_i);
    rsp_valid_i = 1; rsp_err_i = 1;
    @(negedge clk_i); rsp_valid_i = 0; rsp_err_i = 0;
    checks++; if (error_o !== 2'd2) begin failures++; $display("FAIL rsp_err_set got=%0d exp=2", error_o); end
    hs0 = hs_count;
    dmireset_i = 1;
    drive_update(7'h41, 32'h0, 2'd1);
    @(negedge clk_i); dmireset_i = 0; update_i = 0;
    checks++; if (error_o !== 2'd0 || req_valid_o !== 1'b0) begin
      failures++; $display("FAIL dmireset_with_update got err=%0d v=%0b exp err=0 v=0", error_o, req_valid_o); end
    @(negedge clk_i);
    checks++; if (hs_count != hs0 || req_valid_o !== 1'b0) begin
      failures++; $display("FAIL dmireset_no_req got hs=%0d v=%0b exp hs=0 v=0", hs_count - hs0, req_valid_o); end
  endtask

  task automatic test_hardreset();
    req_ready_i = 0;
    drive_update(7'h05, 32'h0, 2'd1);
    @(negedge clk_i); update_i = 0;
    checks++; if (req_valid_o !== 1'b1) begin failures++; $display("FAIL hr_req_pending got=%0b exp=1", req_valid_o); end
    hardreset_i = 1;
    @(negedge clk_i); hardreset_i = 0;
    checks++; if (req_valid_o !== 1'b0 || error_o !== 2'd0) begin
      failures++; $display("FAIL hr_abort got v=%0b err=%0d exp v=0 err=0", req_valid_o, error_o); end
    rsp_valid_i = 1; rsp_data_i = 32'h12345678;
    @(negedge clk_i); rsp_valid_i = 0;
    checks++; if (capt_data_o !== exp_capt || req_valid_o !== 1'b0) begin
      failures++; $display("FAIL hr_late_rsp got capt=%h v=%0b exp capt=%h v=0", capt_data_o, req_valid_o, exp_capt); end
    req_ready_i = 1;
    drive_update(7'h06, 32'h0, 2'd1);
    @(negedge clk_i); update_i = 0;
    checks++; if (req_valid_o !== 1'b1 || req_addr_o !== 7'h06) begin
      failures++; $display("FAIL hr_idle_again got v=%0b a=%h exp v=1 a=06", req_valid_o, req_addr_o); end
    @(negedge clk_i);
    rsp_valid_i = 1; rsp_data_i = 32'h0BADF00D;
    @(negedge clk_i); rsp_valid_i = 0;
    exp_capt = 32'h0BADF00D;
    checks++; if (capt_data_o !== 32'h0BADF00D) begin failures++; $display("FAIL hr_next_read got=%h exp=0badf00d", capt_data_o); end
  endtask

  task automatic test_timeout();
    req_ready_i = 1;
    drive_update(7'h07, 32'h0, 2'd1);
    @(negedge clk_i); update_i = 0;
`ifdef DMI_BUSY_TIMEOUT_EN
    // Handshake at the next edge; 7 more edges leave 7 wait cycles done.
    repeat (8) @(negedge clk_i);
    checks++; if (error_o !== 2'd0) begin failures++; $display("FAIL timeout_early got=%0d exp=0", error_o); end
    @(negedge clk_i);
    checks++; if (error_o !== 2'd2) begin failures++; $display("FAIL timeout_fire got=%0d exp=2", error_o); end
    rsp_valid_i = 1; rsp_data_i = 32'h77777777;
    @(negedge clk_i); rsp_valid_i = 0;
    checks++; if (capt_data_o !== exp_capt || req_valid_o !== 1'b0) begin
      failures++; $display("FAIL timeout_late_rsp got capt=%h v=%0b exp capt=%h v=0", capt_data_o, req_valid_o, exp_capt); end
    dmireset_i = 1;
    @(negedge clk_i); dmireset_i = 0;
`else
    repeat (20) @(negedge clk_i);
    checks++; if (error_o !== 2'd0 || req_valid_o !== 1'b0) begin
      failures++; $display("FAIL no_timeout_wait got err=%0d v=%0b exp err=0 v=0", error_o, req_valid_o); end
    rsp_valid_i = 1; rsp_data_i = 32'h77777777;
    @(negedge clk_i); rsp_valid_i = 0;
    exp_capt = 32'h77777777;
    checks++; if (capt_data_o !== 32'h77777777) begin failures++; $display("FAIL no_timeout_rsp got=%h exp=77777777", capt_data_o); end
`endif
  endtask

  task automatic test_mid_rst();
    req_ready_i = 1;
    drive_update(7'h08, 32'h0, 2'd1);
    @(negedge clk_i); update_i = 0;
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i); rst_i = 0;
    rsp_valid_i = 1; rsp_data_i = 32'hFFFF0000;
    @(negedge clk_i); rsp_valid_i = 0;
    checks++; if (capt_data_o !== 32'd0 || error_o !== 2'd0 || req_valid_o !== 1'b0) begin
      failures++; $display("FAIL mid_rst got capt=%h err=%0d v=%0b exp capt=0 err=0 v=0", capt_data_o, error_o, req_valid_o); end
  endtask

  task automatic test_random();
    int hs0;
    clear_inputs();
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    m_busy = 0; m_granted = 0; m_err = 0; m_capt = 0; m_wait = 0; m_hs_exp = 0;
    m_addr = 0; m_data = 0; m_op = 0;
    hs0 = hs_count;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      checks++; if (req_valid_o !== (m_busy && !m_granted)) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, req_valid_o, m_busy && !m_granted); end
      if (m_busy && !m_granted) begin
        checks++; if ({req_addr_o, req_data_o, req_op_o} !== {m_addr, m_data, m_op}) begin
          failures++; $display("FAIL rand_payload cyc=%0d got=%h exp=%h", cyc, {req_addr_o, req_data_o, req_op_o}, {m_addr, m_data, m_op}); end
      end
      checks++; if (error_o !== m_err) begin failures++; $display("FAIL rand_error cyc=%0d got=%0d exp=%0d", cyc, error_o, m_err); end
      checks++; if (capt_data_o !== m_capt) begin failures++; $display("FAIL rand_capt cyc=%0d got=%h exp=%h", cyc, capt_data_o, m_capt); end
      update_i     = ($urandom_range(0, 3) == 0);
      capture_i    = ($urandom_range(0, 7) == 0);
      dmi_select_i = ($urandom_range(0, 7) != 0);
      dr_addr_i    = 7'($urandom);
      dr_data_i    = $urandom;
      dr_op_i      = 2'($urandom_range(0, 3));
      dmireset_i   = ($urandom_range(0, 15) == 0);
      hardreset_i  = ($urandom_range(0, 63) == 0);
      req_ready_i  = ($urandom_range(0, 1) == 0);
      rsp_valid_i  = ($urandom_range(0, 5) == 0);
      rsp_data_i   = $urandom;
      rsp_err_i    = ($urandom_range(0, 3) == 0);
      step_model();
    end
    @(negedge clk_i);
    clear_inputs();
    checks++; if (hs_count - hs0 !== m_hs_exp) begin
      failures++; $display("FAIL rand_hs_count got=%0d exp=%0d", hs_count - hs0, m_hs_exp); end
  endtask

  initial begin
    exp_capt = '0;
    test_reset();
    test_read();
    test_nop_reserved();
    test_busy();
    test_rsp_err();
    test_hardreset();
    test_timeout();
    test_mid_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
